mem_wb_elastic_reg: RTL and testbench

//  Elastic MEM->WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/mem_wb_elastic_reg.sv | 156 +++++++++++++++
 tb/tb_mem_wb_elastic_reg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_elastic_reg.sv
// rtl/mem_wb_elastic_reg.sv - elastic MEM->WB pipeline register with 2-entry skid buffer
//
// Purpose:
//   Sits between the MEM stage and the register-file write port. It holds up to
//   two instructions (main + skid) under valid/ready flow control. It merges the
//   load/ALU result path and the link-address path into one writeback port, and
//   counts retired instructions.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop every held and incoming entry this cycle
//   MEM_*           upstream handshake (MEM_valid/MEM_ready) and payload
//   WB_*            downstream handshake (WB_valid/WB_ready) and selected payload
//   WB_retired      number of completed WB handshakes, wraps modulo 2^CNT_W
module mem_wb_elastic_reg #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               MEM_valid,
    output logic               MEM_ready,
    input  logic [XLEN-1:0]    MEM_data_mem,
    input  logic [RADDR_W-1:0] MEM_rd,
    input  logic               MEM_we,
    input  logic [XLEN-1:0]    MEM_link_addr,
    input  logic               MEM_link_we,
    output logic               WB_valid,
    input  logic               WB_ready,
    output logic [XLEN-1:0]    WB_wdata,
    output logic [RADDR_W-1:0] WB_rd,
    output logic               WB_we,
    output logic               WB_is_link,
    output logic [CNT_W-1:0]   WB_retired
);

    // Encoding is {main valid, skid valid}, so the state bits double as the
    // occupancy flags.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]    main_wdata_q, skid_wdata_q;
    logic [RADDR_W-1:0] main_rd_q,    skid_rd_q;
    logic               main_we_q,    skid_we_q;
    logic               main_link_q,  skid_link_q;
    logic [CNT_W-1:0]   retired_q;

    logic acc, con;
    logic load_main_in, load_main_skid, load_skid;

    // Payload as it would be captured this cycle. Writes to x0 are suppressed
    // but the link tag is preserved.
    logic [XLEN-1:0] cap_wdata;
    logic            cap_we;

    assign cap_wdata = MEM_link_we ? MEM_link_addr : MEM_data_mem;
    assign cap_we    = (MEM_link_we | MEM_we) & (MEM_rd != '0);

    // MEM_ready comes straight off the skid-valid flop. It has no path from
    // WB_ready. It is held low while reset is asserted.
    assign MEM_ready = ~state_q[0] & ~rst;
    assign WB_valid  = state_q[1];
    assign acc       = MEM_valid & MEM_ready;
    assign con       = WB_valid & WB_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (acc && con) begin
                    load_main_in = 1'b1;
                end else if (acc) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (con) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (con) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush discards everything, including an entry accepted this cycle.
        // A consume in the same cycle still retires.
        if (flush) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            main_wdata_q <= '0;
            main_rd_q    <= '0;
            main_we_q    <= 1'b0;
            main_link_q  <= 1'b0;
            skid_wdata_q <= '0;
            skid_rd_q    <= '0;
            skid_we_q    <= 1'b0;
            skid_link_q  <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q <= state_d;
            if (con) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (load_main_in) begin
                main_wdata_q <= cap_wdata;
                main_rd_q    <= MEM_rd;
                main_we_q    <= cap_we;
                main_link_q  <= MEM_link_we;
            end else if (load_main_skid) begin
                main_wdata_q <= skid_wdata_q;
                main_rd_q    <= skid_rd_q;
                main_we_q    <= skid_we_q;
                main_link_q  <= skid_link_q;
            end
            if (load_skid) begin
                skid_wdata_q <= cap_wdata;
                skid_rd_q    <= MEM_rd;
                skid_we_q    <= cap_we;
                skid_link_q  <= MEM_link_we;
            end
        end
    end

    assign WB_wdata   = main_wdata_q;
    assign WB_rd      = main_rd_q;
    assign WB_we      = main_we_q & WB_valid;
    assign WB_is_link = main_link_q;
    assign WB_retired = retired_q;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// tb/tb_mem_wb_elastic_reg.sv - self-checking bench for mem_wb_elastic_reg
module tb_mem_wb_elastic_reg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               flush = 1'b0;
    logic               mem_valid = 1'b0;
    logic               mem_ready;
    logic [XLEN-1:0]    mem_data = '0;
    logic [RADDR_W-1:0] mem_rd = '0;
    logic               mem_we = 1'b0;
    logic [XLEN-1:0]    link_addr = '0;
    logic               link_we = 1'b0;
    logic               wb_valid;
    logic               wb_ready = 1'b0;
    logic [XLEN-1:0]    wb_wdata;
    logic [RADDR_W-1:0] wb_rd;
    logic               wb_we;
    logic               wb_is_link;
    logic [CNT_W-1:0]   wb_retired;

    mem_wb_elastic_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .MEM_valid(mem_valid), .MEM_ready(mem_ready),
        .MEM_data_mem(mem_data), .MEM_rd(mem_rd), .MEM_we(mem_we),
        .MEM_link_addr(link_addr), .MEM_link_we(link_we),
        .WB_valid(wb_valid), .WB_ready(wb_ready),
        .WB_wdata(wb_wdata), .WB_rd(wb_rd), .WB_we(wb_we),
        .WB_is_link(wb_is_link), .WB_retired(wb_retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]    wdata;
        logic [RADDR_W-1:0] rd;
        logic               we;
        logic               is_link;
    } ent_t;

    ent_t q[$];
    int   cnt_m = 0;
    int   n_total = 0;
    int   n_pass = 0;
    bit   last_acc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic compare_all();
        check("wb_valid", 64'(wb_valid), 64'(q.size() > 0));
        check("mem_ready", 64'(mem_ready), rst ? 64'd0 : 64'(q.size() < 2));
        check("retired", 64'(wb_retired), 64'(cnt_m));
        if (q.size() > 0) begin
            check("wdata", 64'(wb_wdata), 64'(q[0].wdata));
            check("rd", 64'(wb_rd), 64'(q[0].rd));
            check("we", 64'(wb_we), 64'(q[0].we));
            check("is_link", 64'(wb_is_link), 64'(q[0].is_link));
        end else begin
            check("we_idle", 64'(wb_we), 64'd0);
        end
    endtask

    // One clock: the queue model is FIFO with capacity two, and it is advanced
    // from the inputs presented before the edge.
    task automatic tick();
        bit   acc, con;
        ent_t e;
        acc       = mem_valid && !rst && (q.size() < 2);
        con       = !rst && (q.size() > 0) && wb_ready;
        e.wdata   = link_we ? link_addr : mem_data;
        e.rd      = mem_rd;
        e.is_link = link_we;
        e.we      = (link_we || mem_we) && (mem_rd != 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            cnt_m = 0;
        end else begin
            if (con) begin
                void'(q.pop_front());
                cnt_m = (cnt_m + 1) % (1 << CNT_W);
            end
            if (flush) q.delete();
            else if (acc) q.push_back(e);
        end
        last_acc = acc && !flush;
        #1;
        compare_all();
    endtask

    task automatic send(input logic [XLEN-1:0] d, input logic [RADDR_W-1:0] rd,
                        input logic we, input logic [XLEN-1:0] la, input logic lwe);
        bit done;
        done      = 0;
        mem_valid = 1'b1;
        mem_data  = d;
        mem_rd    = rd;
        mem_we    = we;
        link_addr = la;
        link_we   = lwe;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            done = last_acc;
        end
        if (!done) check("send_timeout", 64'(done), 64'd1);
        mem_valid = 1'b0;
    endtask

    initial begin
        // Reset held two cycles with MEM_valid high.
        rst = 1'b1;
        mem_valid = 1'b1;
        tick();
        tick();
        check("rst_ready", 64'(mem_ready), 64'd0);
        check("rst_wdata", 64'(wb_wdata), 64'd0);
        check("rst_is_link", 64'(wb_is_link), 64'd0);
        rst = 1'b0;
        mem_valid = 1'b0;
        #1;
        check("ready_after_rst", 64'(mem_ready), 64'd1);

        // Streaming with WB_ready held high.
        wb_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(32'h10 * i, RADDR_W'(i), 1'b1, 32'h0, 1'b0);
            check("stream_rd", 64'(wb_rd), 64'(i));
        end
        tick();
        check("stream_retired", 64'(wb_retired), 64'd4);

        // Backpressure: A, B fill the buffer, C must wait.
        wb_ready = 1'b0;
        send(32'hA, 5'd5, 1'b1, 32'h0, 1'b0);
        send(32'hB, 5'd6, 1'b1, 32'h0, 1'b0);
        mem_valid = 1'b1;
        mem_data  = 32'hC;
        mem_rd    = 5'd7;
        tick();
        tick();
        check("full_ready", 64'(mem_ready), 64'd0);
        check("full_head", 64'(wb_rd), 64'd5);
        wb_ready = 1'b1;
        for (int i = 0; i < 10 && !last_acc; i++) tick();
        mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("bp_retired", 64'(wb_retired), 64'd7);

        // Link merge.
        wb_ready = 1'b0;
        send(32'hDEAD, 5'd31, 1'b0, 32'h1004, 1'b1);
        check("link_wdata", 64'(wb_wdata), 64'h1004);
        check("link_we", 64'(wb_we), 64'd1);
        check("link_tag", 64'(wb_is_link), 64'd1);
        wb_ready = 1'b1;
        tick();

        // x0 suppression on both paths.
        wb_ready = 1'b0;
        send(32'h55, 5'd0, 1'b1, 32'h0, 1'b0);
        check("x0_valid", 64'(wb_valid), 64'd1);
        check("x0_we", 64'(wb_we), 64'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        send(32'h66, 5'd0, 1'b0, 32'h2000, 1'b1);
        check("x0_link_we", 64'(wb_we), 64'd0);
        check("x0_link_tag", 64'(wb_is_link), 64'd1);
        wb_ready = 1'b1;
        tick();

        // Flush from FULL with a simultaneous incoming entry.
        wb_ready = 1'b0;
        send(32'h1, 5'd1, 1'b1, 32'h0, 1'b0);
        send(32'h2, 5'd2, 1'b1, 32'h0, 1'b0);
        check("pre_flush_ready", 64'(mem_ready), 64'd0);
        flush = 1'b1;
        mem_valid = 1'b1;
        tick();
        flush = 1'b0;
        mem_valid = 1'b0;
        check("flush_valid", 64'(wb_valid), 64'd0);
        check("flush_ready", 64'(mem_ready), 64'd1);

        // Counter wrap: 17 handshakes on a 4-bit counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(32'(i), 5'd3, 1'b1, 32'h0, 1'b0);
        tick();
        check("retired_wrap", 64'(wb_retired), 64'd1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            mem_valid = 1'($urandom_range(0, 3) != 0);
            wb_ready  = 1'($urandom_range(0, 2) != 0);
            flush     = 1'($urandom_range(0, 15) == 0);
            mem_data  = $urandom;
            link_addr = $urandom;
            mem_rd    = RADDR_W'($urandom_range(0, 31));
            mem_we    = 1'($urandom_range(0, 1));
            link_we   = 1'($urandom_range(0, 3) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
